// File: rtl/ram_3_pkg.sv
// Shared defaults, sequencer state type and address helper for the ram_3 byte RAM.
package ram_3_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 1024;
   localparam int unsigned ADDR_W_DEF = 10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic int unsigned last_addr(input int unsigned depth);
      return depth - 1;
   endfunction

endpackage

// File: rtl/ram_3_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then raises ready.
module ram_3_clear_seq
   import ram_3_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(last_addr(DEPTH));

   state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         ready    <= 1'b0;
         clr_we   <= 1'b1;
         clr_addr <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               // The last location is written on this same edge, so leave CLEAR now.
               if (clr_addr == LAST) begin
                  state  <= ST_READY;
                  ready  <= 1'b1;
                  clr_we <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            ST_READY: begin
               state  <= ST_READY;
               ready  <= 1'b1;
               clr_we <= 1'b0;
            end
            default: begin
               state  <= ST_CLEAR;
               ready  <= 1'b0;
               clr_we <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/ram_3_sram.sv
// Single-port synchronous byte RAM with registered read, write-through and post-reset clear.
module ram_3_sram
   import ram_3_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              ready
);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   ram_3_clear_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

   // Sequencer owns the array until ready; user port is ignored meanwhile.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_wdata = data_in;
      if (!ready) begin
         mem_we    = clr_we;
         mem_addr  = clr_addr;
         mem_wdata = '0;
      end else begin
         mem_we = cs & wr & in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
      end else if (!ready) begin
         data_out <= '0;
      end else if (cs) begin
         if (wr) begin
            data_out <= data_in;
         end else begin
            data_out <= in_range ? mem[addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_3_sram.sv
// Self-checking bench for ram_3_sram: directed scenarios plus randomized traffic against an array model.
module tb_ram_3_sram;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cs;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          ready;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] model_dout;

   always #5 clk = ~clk;

   ram_3_sram #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs       (cs),
      .wr       (wr),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .ready    (ready)
   );

   // Drive one access, advance one edge, return the sampled output.
   task automatic op(input logic c, input logic w, input int unsigned a,
                     input logic [DW-1:0] d, output logic [DW-1:0] q);
      cs      = c;
      wr      = w;
      addr    = AW'(a);
      data_in = d;
      @(posedge clk);
      #1;
      q = data_out;
   endtask

   task automatic idle();
      cs = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
   endtask

   // Waits for ready with a cycle budget; returns edges counted (budget+1 on timeout).
   task automatic wait_ready(output int unsigned cycles);
      cycles = 0;
      while (cycles <= 2 * DEPTH) begin
         @(posedge clk);
         #1;
         cycles++;
         if (ready) break;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
      model_dout = '0;
   endtask

   task automatic test_reset();
      int unsigned   cyc;
      logic [DW-1:0] q;
      int unsigned   addrs [3] = '{0, 511, 1023};
      idle();
      rst_n = 1'b0;
      #23;
      n_cmp++;
      if (ready !== 1'b0 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_state: ready=%b data_out=%h, required ready=0 data_out=00", ready, data_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready(cyc);
      n_cmp++;
      if (cyc !== DEPTH) begin
         n_err++;
         $display("FAIL clear_length: ready rose after %0d cycles, required %0d", cyc, DEPTH);
      end
      foreach (addrs[i]) begin
         op(1'b1, 1'b0, addrs[i], 8'h00, q);
         n_cmp++;
         if (q !== 8'h00) begin
            n_err++;
            $display("FAIL cleared_read@%0d: got %h, required 00", addrs[i], q);
         end
      end
      model_clear();
   endtask

   task automatic test_directed();
      int unsigned   a [5] = '{32, 64, 128, 256, 512};
      logic [DW-1:0] d [5] = '{8'hFF, 8'hAC, 8'h9B, 8'h8F, 8'h7F};
      logic [DW-1:0] q;
      for (int i = 0; i < 5; i++) begin
         op(1'b1, 1'b1, a[i], d[i], q);
         model_mem[a[i]] = d[i];
      end
      for (int i = 0; i < 5; i++) begin
         op(1'b1, 1'b0, a[i], 8'h00, q);
         n_cmp++;
         if (q !== d[i]) begin
            n_err++;
            $display("FAIL directed_read@%0d: got %h, required %h", a[i], q, d[i]);
         end
      end
      model_dout = d[4];
   endtask

   task automatic test_write_through();
      logic [DW-1:0] q;
      op(1'b1, 1'b1, 7, 8'h5A, q);
      model_mem[7] = 8'h5A;
      n_cmp++;
      if (q !== 8'h5A) begin
         n_err++;
         $display("FAIL write_through: got %h, required 5a", q);
      end
      op(1'b1, 1'b0, 7, 8'h00, q);
      n_cmp++;
      if (q !== 8'h5A) begin
         n_err++;
         $display("FAIL read_after_write: got %h, required 5a", q);
      end
      model_dout = 8'h5A;
   endtask

   task automatic test_cs_gating();
      logic [DW-1:0] q;
      op(1'b1, 1'b1, 100, 8'h11, q);
      model_mem[100] = 8'h11;
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 1'b1, 100, 8'h22, q);
         n_cmp++;
         if (q !== 8'h11) begin
            n_err++;
            $display("FAIL cs_hold cycle %0d: got %h, required 11", i, q);
         end
      end
      op(1'b1, 1'b0, 100, 8'h00, q);
      n_cmp++;
      if (q !== 8'h11) begin
         n_err++;
         $display("FAIL cs_gated_write: got %h, required 11", q);
      end
      model_dout = 8'h11;
   endtask

   task automatic test_clear_access();
      logic [DW-1:0] q;
      int unsigned   cyc;
      idle();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         if (i == 5) op(1'b1, 1'b1, 3, 8'hEE, q);
         else        op(1'b0, 1'b0, 0, 8'h00, q);
         n_cmp++;
         if (q !== 8'h00 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_hold cycle %0d: data_out=%h ready=%b, required 00/0", i, q, ready);
         end
      end
      idle();
      wait_ready(cyc);
      n_cmp++;
      if (cyc !== DEPTH - 6) begin
         n_err++;
         $display("FAIL clear_length2: ready after %0d more cycles, required %0d", cyc, DEPTH - 6);
      end
      op(1'b1, 1'b0, 3, 8'h00, q);
      n_cmp++;
      if (q !== 8'h00) begin
         n_err++;
         $display("FAIL clear_ignores_write@3: got %h, required 00", q);
      end
      model_clear();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] q, d;
      logic          c, w;
      int unsigned   a;
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(0, 9) < 8);
         w = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 15);
         d = DW'($urandom);
         op(c, w, a, d, q);
         if (c && w) begin
            model_mem[a] = d;
            model_dout   = d;
         end else if (c) begin
            model_dout = model_mem[a];
         end
         n_cmp++;
         if (q !== model_dout) begin
            n_err++;
            $display("FAIL random op %0d (cs=%b wr=%b addr=%0d): got %h, required %h", i, c, w, a, q, model_dout);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] q;
      int unsigned   cyc;
      op(1'b1, 1'b1, 1023, 8'hC3, q);
      idle();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (data_out !== 8'h00 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: data_out=%h ready=%b, required 00/0", data_out, ready);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      wait_ready(cyc);
      n_cmp++;
      if (cyc !== DEPTH) begin
         n_err++;
         $display("FAIL reclear_length: %0d cycles, required %0d", cyc, DEPTH);
      end
      op(1'b1, 1'b0, 1023, 8'h00, q);
      n_cmp++;
      if (q !== model_mem[1023]) begin
         n_err++;
         $display("FAIL reclear_read@1023: got %h, required %h", q, model_mem[1023]);
      end
      op(1'b1, 1'b0, 7, 8'h00, q);
      n_cmp++;
      if (q !== model_mem[7]) begin
         n_err++;
         $display("FAIL reclear_read@7: got %h, required %h", q, model_mem[7]);
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b1;
      model_clear();
      test_reset();
      test_directed();
      test_write_through();
      test_cs_gating();
      test_clear_access();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_3_sram.md
Name: ram_3_sram

Overview:
- Single-port synchronous byte RAM: 1024 x 8 by default, with chip-select and write-enable.
- Serves as a general scratch/storage block for byte-wide datapaths.
- Contains a built-in clear sequencer that zeroes every location after reset and flags readiness.
- Reads are registered with one-cycle latency.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 1024, number of words.
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select; access occurs only when high.
- wr  input  1  1 = write, 0 = read; qualified by cs.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- ready  output  1  high once the post-reset clear has completed.

Behaviour:
- Reset (rst_n low, asynchronous): data_out = 0, ready = 0, clear pointer = 0, FSM enters CLEAR. Memory contents are not touched asynchronously.
- FSM has two states:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. When ptr = DEPTH-1 is written, the next state is READY and ready goes to 1 on that same edge. A full clear takes DEPTH cycles after rst_n deasserts.
  - READY: normal operation; stays here until the next reset.
- While in CLEAR:
  - all cs/wr accesses are ignored (no write);
  - data_out is held at 0.
- While in READY, on each rising clk:
  - cs=1, wr=1: mem[addr] <= data_in. data_out <= data_in (write-through, so the written value is visible the next cycle).
  - cs=1, wr=0: data_out <= mem[addr]. Latency is one cycle: addr presented at edge N gives data valid after edge N.
  - cs=0: no memory change; data_out holds its last value.
- Out-of-range addresses (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W): writes are ignored; reads return 0.
- Back-to-back accesses are allowed every cycle, with no bubbles.
- Write followed by a read of the same address on the next cycle returns the new data.
- Reset asserted mid-operation: outputs clear immediately and the full clear sequence restarts on release. All contents are zeroed again, including prior writes.
- Memory is inferred as a single-port array with a synchronous write and a registered read.

Decomposition:
- Shared package ram_3_pkg holds:
  - DATA_W/DEPTH/ADDR_W defaults;
  - the FSM state enum (ST_CLEAR, ST_READY);
  - a function returning the last valid address (DEPTH-1).
- One sub-module, ram_3_clear_seq: owns the FSM and clear pointer. It outputs ready, plus the clr_we and clr_addr that override the user port during CLEAR.
- The top level muxes the sequencer and user port onto the array.

Test Plan:
- Reset/clear: pulse rst_n low, release, hold cs=0.
  - ready = 0 for exactly 1024 cycles, then 1.
  - Reads of addresses 0, 511, 1023 return 0x00.
- Directed writes then readback, with cs=1 throughout:
  - Write 0xFF@32, 0xAC@64, 0x9B@128, 0x8F@256, 0x7F@512.
  - Then read 32, 64, 128, 256, 512.
  - data_out = FF, AC, 9B, 8F, 7F, each one cycle after its address.
- Write-through and latency:
  - Write 0x5A@7 and check data_out = 0x5A the next cycle.
  - Read @7 immediately after and check data_out = 0x5A.
- Chip-select gating:
  - After loading 0x11@100, drive cs=0, wr=1, data_in=0x22, addr=100 for 3 cycles: data_out unchanged.
  - A subsequent read @100 returns 0x11.
- Access during CLEAR: issue a write 0xEE@3 during cycle 5 after reset release. After ready, read @3 returns 0x00.
- Reset mid-operation:
  - Write 0xC3@1023, assert rst_n low for 2 cycles.
  - data_out = 0 immediately (asynchronous).
  - After the re-clear, read @1023 returns 0x00.
